// File: rtl/mem_pkg.sv
// mem_pkg: shared op and FSM state encodings for the storage array controller
package mem_pkg;
    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_CLEAR} op_e;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
endpackage

// File: rtl/mem_word.sv
// mem_word: one storage row of bit cells with per-bit write enable and sync clear
//   clk, rst_n     clock, async active-low reset
//   sel, wr, clr   row select, write strobe, synchronous clear
//   wdata, wmask   write data and per-bit enable
//   q              stored word
module mem_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             wr,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] we;
    assign we = {WIDTH{sel & wr}} & wmask;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else q <= (q & ~we) | (wdata & we);
endmodule

// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl: DEPTH x WIDTH storage array with valid/ready port, masked write, registered read, multi-cycle CLEAR
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_req_valid / o_req_ready            request handshake
//   i_op, i_addr, i_wdata, i_wmask       operation, word address, write data, bit mask
//   o_rdata, o_rvalid                    registered read data, one-cycle result pulse
//   o_busy                               CLEAR sequence in progress
module mem_array_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [WIDTH-1:0]  i_wmask,
    output logic [WIDTH-1:0]  o_rdata,
    output logic              o_rvalid,
    output logic              o_busy
);
    logic [WIDTH-1:0]  rows [DEPTH];
    logic [WIDTH-1:0]  rd;
    logic [ADDR_W-1:0] cnt;
    state_e            state, state_nx;
    op_e               op;
    logic              accept, last, do_read;

    assign op          = op_e'(i_op);
    assign o_req_ready = state == ST_IDLE;
    assign o_busy      = state == ST_CLEAR;
    assign accept      = i_req_valid && o_req_ready;
    assign do_read     = accept && op == OP_READ;
    assign last        = cnt == ADDR_W'(DEPTH - 1);

    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE) ? ((accept && op == OP_CLEAR) ? ST_CLEAR : ST_IDLE)
                                      : (last ? ST_IDLE : ST_CLEAR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (o_busy && !last) ? cnt + 1'b1 : '0;
        end

    // Addresses with no matching row (>= DEPTH) leave no row selected, so
    // writes drop and reads return zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        mem_word #(.WIDTH(WIDTH)) u_word (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .sel   (i_addr == ADDR_W'(i)),
            .wr    (accept && op == OP_WRITE),
            .clr   (o_busy && cnt == ADDR_W'(i)),
            .wdata (i_wdata),
            .wmask (i_wmask),
            .q     (rows[i])
        );
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < DEPTH; i++) rd = (i_addr == ADDR_W'(i)) ? rows[i] : rd;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= do_read;
            if (do_read) o_rdata <= rd;
        end
endmodule

// File: tb/tb_mem_array_ctrl.sv
// tb_mem_array_ctrl: randomized and directed checks of two array sizes against a behavioural model
module tb_mem_array_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid = 1'b0;
    logic [1:0] op = 2'd0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00, wmask = 8'h00;
    logic       ready_a, rvalid_a, busy_a, ready_b, rvalid_b, busy_b;
    logic [7:0] rdata_a, rdata_b;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_array_ctrl u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready_a),
        .i_op(op), .i_addr(addr), .i_wdata(wdata), .i_wmask(wmask),
        .o_rdata(rdata_a), .o_rvalid(rvalid_a), .o_busy(busy_a)
    );

    mem_array_ctrl #(.DEPTH(6)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready_b),
        .i_op(op), .i_addr(addr), .i_wdata(wdata), .i_wmask(wmask),
        .o_rdata(rdata_b), .o_rvalid(rvalid_b), .o_busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: word arrays, number of CLEAR words still to go, last read result.
    logic [7:0] m [2][8];
    int         dep [2] = '{8, 6};
    int         left [2];
    logic [7:0] rd [2];
    bit         rv [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int w = 0; w < 8; w++) m[k][w] = 8'h00;
                left[k] = 0;
                rd[k]   = 8'h00;
                rv[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                rv[k] = 1'b0;
                if (left[k] > 0) begin
                    m[k][dep[k] - left[k]] = 8'h00;
                    left[k]--;
                end else if (valid) begin
                    case (op)
                        2'd1: begin
                            rv[k] = 1'b1;
                            rd[k] = (int'(addr) < dep[k]) ? m[k][addr] : 8'h00;
                        end
                        2'd2: if (int'(addr) < dep[k]) m[k][addr] = (m[k][addr] & ~wmask) | (wdata & wmask);
                        2'd3: left[k] = dep[k];
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(posedge clk) if (rst_n) begin
        #1;
        chk("a_busy", busy_a, left[0] > 0);
        chk("a_ready", ready_a, left[0] == 0);
        chk("a_rvalid", rvalid_a, rv[0]);
        chk("a_rdata", rdata_a, rd[0]);
        chk("b_busy", busy_b, left[1] > 0);
        chk("b_ready", ready_b, left[1] == 0);
        chk("b_rvalid", rvalid_b, rv[1]);
        chk("b_rdata", rdata_b, rd[1]);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d, input logic [7:0] mk);
        int n = 0;
        valid = 1'b1; op = o; addr = a; wdata = d; wmask = mk;
        while (!ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", ready_a, 1);
        @(negedge clk);
        valid = 1'b0; op = 2'd0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_rdata", rdata_a, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        req(2'd1, 3'd3, 8'h00, 8'h00);
        chk("t1_rvalid", rvalid_a, 1);
        chk("t1_rdata", rdata_a, 8'h00);
        chk("t1_ready", ready_a, 1);
        req(2'd2, 3'd5, 8'hA5, 8'hFF);
        chk("t2_norvalid", rvalid_a, 0);
        req(2'd1, 3'd5, 8'h00, 8'h00);
        chk("t2_rdata", rdata_a, 8'hA5);
        req(2'd2, 3'd5, 8'h0F, 8'hF0);
        req(2'd1, 3'd5, 8'h00, 8'h00);
        chk("t3_rdata", rdata_a, 8'h05);
        @(negedge clk);
        chk("t3_hold", rdata_a, 8'h05);
        chk("t3_pulse", rvalid_a, 0);
        for (int w = 0; w < 8; w++) req(2'd2, 3'(w), 8'hFF, 8'hFF);
        req(2'd3, 3'd0, 8'h00, 8'h00);
        valid = 1'b1; op = 2'd1; addr = 3'd2;
        n = 0;
        while (busy_a && n < 20) begin
            chk("t4_ready_low", ready_a, 0);
            n++;
            @(negedge clk);
        end
        chk("t4_clear_cycles", n, 8);
        @(negedge clk);
        valid = 1'b0; op = 2'd0;
        chk("t4_rvalid", rvalid_a, 1);
        chk("t4_rdata", rdata_a, 8'h00);
        for (int w = 0; w < 8; w++) begin
            req(2'd1, 3'(w), 8'h00, 8'h00);
            chk("t4_zero", rdata_a, 8'h00);
        end
        req(2'd2, 3'd1, 8'h3C, 8'hFF);
        req(2'd2, 3'd4, 8'hC3, 8'hFF);
        req(2'd1, 3'd4, 8'h00, 8'h00);
        chk("t5_pre", rdata_a, 8'hC3);
        req(2'd3, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy_a, 0);
        chk("t5_ready", ready_a, 1);
        chk("t5_rdata", rdata_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 8; w++) begin
            req(2'd1, 3'(w), 8'h00, 8'h00);
            chk("t5_zero", rdata_a, 8'h00);
        end
        for (int w = 0; w < 6; w++) req(2'd2, 3'(w), 8'(8'h10 + w), 8'hFF);
        req(2'd2, 3'd7, 8'h5A, 8'hFF);
        req(2'd1, 3'd7, 8'h00, 8'h00);
        chk("t6_b_rvalid", rvalid_b, 1);
        chk("t6_b_rdata", rdata_b, 8'h00);
        chk("t6_a_rdata", rdata_a, 8'h5A);
        for (int w = 0; w < 6; w++) begin
            req(2'd1, 3'(w), 8'h00, 8'h00);
            chk("t6_b_keep", rdata_b, 8'(8'h10 + w));
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            rst_n = (i != 1500);
            r = int'($urandom_range(0, 15));
            valid = 1'($urandom);
            op    = (r == 0) ? 2'd3 : (r < 6) ? 2'd1 : (r < 11) ? 2'd2 : 2'd0;
            addr  = 3'($urandom);
            wdata = 8'($urandom);
            wmask = 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1; valid = 1'b0; op = 2'd0;
        repeat (12) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
